alu_pwr_ctrl: RTL and testbench
===============================

Name: alu_pwr_ctrl

Overview:
Power-sequencing controller that drives the ALU power domain's control inputs: alu_pwr_en, iso_en, the domain reset and the isolation clamp value. It sits beside the ALU wrapper and converts level power-down/power-up requests into a timed sequence. Power-down runs drain, isolate, then cut power. Power-up runs ramp, hold reset, then release isolation. It also supplies the 16-bit value that downstream logic sees while isolation is active.

Parameters:
ISO_SETUP, 2, cycles iso_en is held before power is removed (>=1)
PWR_RAMP, 4, cycles after alu_pwr_en rises before domain reset may release (>=1)
RST_HOLD, 3, cycles alu_rst_n is held low after ramp and after global reset (>=1)
DRAIN_MAX, 8, maximum cycles waiting for alu_busy to clear before abort (>=1)
CLAMP_MODE, 0, 0 = constant CLAMP_VAL; 1 = last alu_result captured at isolation entry
CLAMP_VAL, 16'h0000, constant clamp and reset value of clamp_value

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
pwr_down_req  in  1  level request to power the ALU off
pwr_up_req  in  1  level request to power the ALU on
alu_busy  in  1  ALU multi-cycle operation in flight
alu_result  in  16  live ALU result, used when CLAMP_MODE=1
alu_pwr_en  out  1  1 = domain powered
iso_en  out  1  1 = domain outputs clamped
alu_rst_n  out  1  domain reset, active-low
clamp_value  out  16  value presented while isolated
pwr_state  out  3  current FSM state encoding
down_done  out  1  one-cycle pulse: domain reached OFF
up_done  out  1  one-cycle pulse: domain reached ON
drain_err  out  1  one-cycle pulse: drain timeout, power-down aborted

Behaviour:
- All outputs registered. Each output is a function of the state, except clamp_value, which is a register.
- Encodings: ON=0, DRAIN=1, ISO=2, OFF=3, RAMP=4, RST=5, UNISO=6.
- Output values per state:
  - ON: pwr=1, iso=0, rst_n=1
  - DRAIN: pwr=1, iso=0, rst_n=1
  - ISO: pwr=1, iso=1, rst_n=1
  - OFF: pwr=0, iso=1, rst_n=0
  - RAMP: pwr=1, iso=1, rst_n=0
  - RST: pwr=1, iso=1, rst_n=0
  - UNISO: pwr=1, iso=1, rst_n=1
- Reset (rst_n=0 at an edge) from any state, including mid-sequence:
  - state=RST, timer=RST_HOLD-1, clamp_value=CLAMP_VAL, all pulses 0.
  - Outputs therefore read pwr=1, iso=1, alu_rst_n=0.
- Timed states (ISO, RAMP, RST) load timer=PARAM-1 on entry, decrement each cycle, and exit on the edge where timer==0. Each timed state is occupied exactly PARAM cycles.
- ON: pwr_down_req=1 moves to DRAIN and clears drain_cnt. pwr_up_req is ignored.
- DRAIN:
  - alu_busy=0 moves to ISO. If CLAMP_MODE=1, clamp_value captures alu_result on that same edge.
  - Otherwise, if drain_cnt==DRAIN_MAX-1, return to ON and pulse drain_err.
  - Otherwise drain_cnt increments.
- ISO: on exit, move to OFF and pulse down_done on the same edge.
- OFF: pwr_up_req=1 moves to RAMP. pwr_down_req is ignored.
- RAMP: on exit, move to RST.
- RST: on exit, move to UNISO.
- UNISO: one cycle, then ON, pulsing up_done on that edge.
- Both requests high in ON or OFF: only the request relevant to the current state acts.
- Requests are not latched. Requests arriving in transient states are ignored; the requester holds the level until it sees the done pulse.
- clamp_value when CLAMP_MODE=0: constant CLAMP_VAL. When CLAMP_MODE=1: holds the captured value until the next capture or reset.
- Latencies with default parameters:
  - First rising edge with rst_n=1 is edge 1. alu_rst_n rises after edge 3 and iso_en falls after edge 4.
  - Power-down: req sampled at edge k (ON→DRAIN), DRAIN→ISO at k+1 if not busy, OFF at k+3.
  - Power-up: req sampled at edge k, RST at k+4, UNISO at k+7, ON at k+8.

Decomposition:
- Package alu_pwr_pkg holds the state enum (3-bit) and a CLAMP_MODE constant pair (CLAMP_CONST=0, CLAMP_HOLD=1).
- One natural sub-module: pwr_timer, a loadable down-counter with a zero flag, shared by ISO, RAMP and RST. The DRAIN counter stays inline.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles, then release → alu_rst_n=0, iso_en=1, alu_pwr_en=1 during reset; alu_rst_n=1 after 3rd edge; iso_en=0 and pwr_state=0 after 4th edge; clamp_value=16'h0000.
- Power-down, idle ALU: alu_busy=0, pwr_down_req=1 at edge k → iso_en=1 after k+1; alu_pwr_en=0, down_done=1 for exactly one cycle after k+3; pwr_state=3.
- Power-down with busy then clear: alu_busy=1 for 5 cycles → stays in DRAIN 5 extra cycles, no drain_err; with CLAMP_MODE=1 and alu_result=16'hBEEF at the DRAIN→ISO edge → clamp_value=16'hBEEF held through OFF.
- Drain timeout: alu_busy stuck at 1, pwr_down_req=1 → after 8 DRAIN cycles drain_err pulses once, pwr_state=0, iso_en never asserted; with the request held, DRAIN re-enters on the next edge.
- Power-up: from OFF, pwr_up_req=1 at edge k → alu_pwr_en=1 after k; alu_rst_n=0 until k+7; iso_en=0 and up_done pulse after k+8.
- Reset mid-sequence: assert rst_n=0 while in RAMP → next state RST, timer=2, clamp_value reset to CLAMP_VAL, no done pulse emitted.

Source files
------------

// File: rtl/alu_pwr_pkg.sv
// Shared definitions for the ALU power-domain sequencer: state encodings,
// clamp-mode selectors and small elaboration-time helpers.
package alu_pwr_pkg;

  typedef logic [2:0] pwr_state_t;

  // Encodings are visible on pwr_state, so they are fixed values.
  localparam pwr_state_t StOn    = 3'd0;
  localparam pwr_state_t StDrain = 3'd1;
  localparam pwr_state_t StIso   = 3'd2;
  localparam pwr_state_t StOff   = 3'd3;
  localparam pwr_state_t StRamp  = 3'd4;
  localparam pwr_state_t StRst   = 3'd5;
  localparam pwr_state_t StUniso = 3'd6;

  localparam int unsigned CLAMP_CONST = 0;
  localparam int unsigned CLAMP_HOLD  = 1;

  // Bits needed to hold values 0..n-1, never less than one.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Domain control levels for a state, packed as {alu_pwr_en, iso_en, alu_rst_n}.
  function automatic logic [2:0] state_ctrl(input pwr_state_t s);
    logic [2:0] c;
    case (s)
      StOn:    c = 3'b101;
      StDrain: c = 3'b101;
      StIso:   c = 3'b111;
      StOff:   c = 3'b010;
      StRamp:  c = 3'b110;
      StRst:   c = 3'b110;
      StUniso: c = 3'b111;
      default: c = 3'b110;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/alu_pwr_ctrl_timer.sv
// Loadable down-counter with a zero flag; one instance serves every timed
// state of the power sequencer since only one is ever active at a time.
module pwr_timer #(
  parameter int unsigned W       = 2,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt_q;

  // Load on state entry, otherwise count down and park at zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= RST_VAL;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/alu_pwr_ctrl.sv
// ALU power-domain sequencer. Turns level power-down/up requests into the
// drain -> isolate -> power-off and ramp -> reset -> un-isolate sequences,
// and supplies the value downstream logic sees while the domain is isolated.
module alu_pwr_ctrl
  import alu_pwr_pkg::*;
#(
  parameter int unsigned  ISO_SETUP  = 2,
  parameter int unsigned  PWR_RAMP   = 4,
  parameter int unsigned  RST_HOLD   = 3,
  parameter int unsigned  DRAIN_MAX  = 8,
  parameter int unsigned  CLAMP_MODE = CLAMP_CONST,
  parameter logic [15:0]  CLAMP_VAL  = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pwr_down_req,
  input  logic        pwr_up_req,
  input  logic        alu_busy,
  input  logic [15:0] alu_result,
  output logic        alu_pwr_en,
  output logic        iso_en,
  output logic        alu_rst_n,
  output logic [15:0] clamp_value,
  output logic [2:0]  pwr_state,
  output logic        down_done,
  output logic        up_done,
  output logic        drain_err
);

  localparam int unsigned TW = cnt_width(max3(ISO_SETUP, PWR_RAMP, RST_HOLD));
  localparam int unsigned DW = cnt_width(DRAIN_MAX);

  // Timer preloads are PARAM-1 so each timed state lasts exactly PARAM cycles.
  localparam logic [TW-1:0] ISO_LD  = TW'(ISO_SETUP - 1);
  localparam logic [TW-1:0] RAMP_LD = TW'(PWR_RAMP - 1);
  localparam logic [TW-1:0] RST_LD  = TW'(RST_HOLD - 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_MAX - 1);

  localparam logic [2:0] RST_CTRL = state_ctrl(StRst);

  pwr_state_t    state_q, state_d;
  logic [DW-1:0] drain_cnt_q, drain_cnt_d;
  logic          tmr_load;
  logic [TW-1:0] tmr_val;
  logic          tmr_zero;
  logic          capture;
  logic          down_done_d, up_done_d, drain_err_d;
  logic [2:0]    ctrl_d;

  pwr_timer #(
    .W       (TW),
    .RST_VAL (RST_LD)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  // Next-state, timer load and completion pulses.
  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    tmr_load    = 1'b0;
    tmr_val     = ISO_LD;
    capture     = 1'b0;
    down_done_d = 1'b0;
    up_done_d   = 1'b0;
    drain_err_d = 1'b0;
    case (state_q)
      StOn: begin
        if (pwr_down_req) begin
          state_d     = StDrain;
          drain_cnt_d = '0;
        end
      end
      StDrain: begin
        if (!alu_busy) begin
          state_d  = StIso;
          tmr_load = 1'b1;
          tmr_val  = ISO_LD;
          capture  = 1'b1;
        end else if (drain_cnt_q == DRAIN_LAST) begin
          // ALU never went idle: abandon the power-down and stay powered.
          state_d     = StOn;
          drain_err_d = 1'b1;
        end else begin
          drain_cnt_d = drain_cnt_q + 1'b1;
        end
      end
      StIso: begin
        if (tmr_zero) begin
          state_d     = StOff;
          down_done_d = 1'b1;
        end
      end
      StOff: begin
        if (pwr_up_req) begin
          state_d  = StRamp;
          tmr_load = 1'b1;
          tmr_val  = RAMP_LD;
        end
      end
      StRamp: begin
        if (tmr_zero) begin
          state_d  = StRst;
          tmr_load = 1'b1;
          tmr_val  = RST_LD;
        end
      end
      StRst: begin
        if (tmr_zero) begin
          state_d = StUniso;
        end
      end
      StUniso: begin
        state_d   = StOn;
        up_done_d = 1'b1;
      end
      default: begin
        // Unused encoding: recover through the power-up reset hold.
        state_d  = StRst;
        tmr_load = 1'b1;
        tmr_val  = RST_LD;
      end
    endcase
  end

  assign ctrl_d = state_ctrl(state_d);

  // State, drain counter and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StRst;
      drain_cnt_q <= '0;
      alu_pwr_en  <= RST_CTRL[2];
      iso_en      <= RST_CTRL[1];
      alu_rst_n   <= RST_CTRL[0];
      down_done   <= 1'b0;
      up_done     <= 1'b0;
      drain_err   <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      alu_pwr_en  <= ctrl_d[2];
      iso_en      <= ctrl_d[1];
      alu_rst_n   <= ctrl_d[0];
      down_done   <= down_done_d;
      up_done     <= up_done_d;
      drain_err   <= drain_err_d;
    end
  end

  // Clamp register: constant, or the last result seen as isolation begins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clamp_value <= CLAMP_VAL;
    end else if (capture && (CLAMP_MODE == CLAMP_HOLD)) begin
      clamp_value <= alu_result;
    end
  end

  assign pwr_state = state_q;

endmodule

// File: tb/tb_alu_pwr_ctrl.sv
// Bench for alu_pwr_ctrl: a directed vector table, hand-written multi-cycle
// corner sequences, then random stimulus against a phase/countdown model.
// Two instances share stimulus: constant clamp and capture-on-isolate clamp.
module tb_alu_pwr_ctrl;

  localparam int ISO_SETUP = 2;
  localparam int PWR_RAMP  = 4;
  localparam int RST_HOLD  = 3;
  localparam int DRAIN_MAX = 8;
  localparam logic [15:0] CLAMP_VAL = 16'h0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pwr_down_req = 1'b0;
  logic        pwr_up_req = 1'b0;
  logic        alu_busy = 1'b0;
  logic [15:0] alu_result = '0;

  logic        alu_pwr_en, iso_en, alu_rst_n, down_done, up_done, drain_err;
  logic [15:0] clamp_value;
  logic [2:0]  pwr_state;
  logic        h_pwr_en, h_iso_en, h_rst_n, h_down_done, h_up_done, h_drain_err;
  logic [15:0] h_clamp;
  logic [2:0]  h_state;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_pwr_ctrl #(
    .ISO_SETUP(ISO_SETUP), .PWR_RAMP(PWR_RAMP), .RST_HOLD(RST_HOLD),
    .DRAIN_MAX(DRAIN_MAX), .CLAMP_MODE(0), .CLAMP_VAL(CLAMP_VAL)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .pwr_down_req(pwr_down_req), .pwr_up_req(pwr_up_req),
    .alu_busy(alu_busy), .alu_result(alu_result), .alu_pwr_en(alu_pwr_en),
    .iso_en(iso_en), .alu_rst_n(alu_rst_n), .clamp_value(clamp_value),
    .pwr_state(pwr_state), .down_done(down_done), .up_done(up_done),
    .drain_err(drain_err)
  );

  alu_pwr_ctrl #(
    .ISO_SETUP(ISO_SETUP), .PWR_RAMP(PWR_RAMP), .RST_HOLD(RST_HOLD),
    .DRAIN_MAX(DRAIN_MAX), .CLAMP_MODE(1), .CLAMP_VAL(CLAMP_VAL)
  ) u_dut_h (
    .clk(clk), .rst_n(rst_n), .pwr_down_req(pwr_down_req), .pwr_up_req(pwr_up_req),
    .alu_busy(alu_busy), .alu_result(alu_result), .alu_pwr_en(h_pwr_en),
    .iso_en(h_iso_en), .alu_rst_n(h_rst_n), .clamp_value(h_clamp),
    .pwr_state(h_state), .down_done(h_down_done), .up_done(h_up_done),
    .drain_err(h_drain_err)
  );

  // Reference model: current phase (numbered as the visible state code),
  // cycles left in a timed phase, busy cycles seen while draining.
  int          m_ph = 5;
  int          m_left = RST_HOLD;
  int          m_drain = 0;
  int          m_dd = 0, m_ud = 0, m_de = 0;
  logic [15:0] m_clh = CLAMP_VAL;

  task automatic model_step();
    if (!rst_n) begin
      m_ph = 5; m_left = RST_HOLD; m_clh = CLAMP_VAL;
      m_dd = 0; m_ud = 0; m_de = 0;
    end else begin
      m_dd = 0; m_ud = 0; m_de = 0;
      case (m_ph)
        0: if (pwr_down_req) begin m_ph = 1; m_drain = 0; end
        1: begin
          if (!alu_busy) begin
            m_ph = 2; m_left = ISO_SETUP; m_clh = alu_result;
          end else begin
            m_drain++;
            if (m_drain == DRAIN_MAX) begin m_ph = 0; m_de = 1; end
          end
        end
        2: begin m_left--; if (m_left == 0) begin m_ph = 3; m_dd = 1; end end
        3: if (pwr_up_req) begin m_ph = 4; m_left = PWR_RAMP; end
        4: begin m_left--; if (m_left == 0) begin m_ph = 5; m_left = RST_HOLD; end end
        5: begin m_left--; if (m_left == 0) m_ph = 6; end
        default: begin m_ph = 0; m_ud = 1; end
      endcase
    end
  endtask

  // Drive inputs, advance the model by one edge, land on the next negedge.
  task automatic apply(input int r, input int d, input int u, input int b, input int res);
    rst_n = r[0]; pwr_down_req = d[0]; pwr_up_req = u[0]; alu_busy = b[0];
    alu_result = res[15:0];
    model_step();
    @(negedge clk);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic exp_outs(input string tag, input int st, input int p, input int i,
                          input int a, input int dd, input int ud, input int de,
                          input int clh);
    chk({tag, ".state"}, int'(pwr_state), st);
    chk({tag, ".pwr_en"}, int'(alu_pwr_en), p);
    chk({tag, ".iso_en"}, int'(iso_en), i);
    chk({tag, ".alu_rst_n"}, int'(alu_rst_n), a);
    chk({tag, ".down_done"}, int'(down_done), dd);
    chk({tag, ".up_done"}, int'(up_done), ud);
    chk({tag, ".drain_err"}, int'(drain_err), de);
    chk({tag, ".clamp"}, int'(clamp_value), int'(CLAMP_VAL));
    chk({tag, ".h_state"}, int'(h_state), st);
    chk({tag, ".h_clamp"}, int'(h_clamp), clh);
  endtask

  // Model-driven expectation; control levels come from the per-state table.
  task automatic exp_model(input string tag);
    int p, i, a;
    p = (m_ph != 3) ? 1 : 0;
    i = (m_ph == 0 || m_ph == 1) ? 0 : 1;
    a = (m_ph <= 2 || m_ph == 6) ? 1 : 0;
    exp_outs(tag, m_ph, p, i, a, m_dd, m_ud, m_de, int'(m_clh));
  endtask

  typedef struct {
    int r, d, u, b, res;
    int st, p, i, a, dd, ud, de, clh;
  } vec_t;

  function automatic vec_t mk(int r, int d, int u, int b, int res, int st, int p, int i,
                              int a, int dd, int ud, int de, int clh);
    vec_t v;
    v.r = r; v.d = d; v.u = u; v.b = b; v.res = res;
    v.st = st; v.p = p; v.i = i; v.a = a; v.dd = dd; v.ud = ud; v.de = de; v.clh = clh;
    return v;
  endfunction

  vec_t vecs[$];

  initial begin
    // Reset hold, release, power-down idle, power-up with both requests high.
    vecs.push_back(mk(0, 0, 0, 0, 0,       5, 1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,       5, 1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0,       5, 1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0,       5, 1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0,       6, 1, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0,       0, 1, 0, 1, 0, 1, 0, 0));
    vecs.push_back(mk(1, 0, 1, 0, 0,       0, 1, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 'h1234,  1, 1, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 'h1234,  2, 1, 1, 1, 0, 0, 0, 'h1234));
    vecs.push_back(mk(1, 1, 0, 0, 'h5555,  2, 1, 1, 1, 0, 0, 0, 'h1234));
    vecs.push_back(mk(1, 1, 0, 0, 'h5555,  3, 0, 1, 0, 1, 0, 0, 'h1234));
    vecs.push_back(mk(1, 1, 0, 0, 0,       3, 0, 1, 0, 0, 0, 0, 'h1234));
    vecs.push_back(mk(1, 1, 1, 0, 0,       4, 1, 1, 0, 0, 0, 0, 'h1234));
    for (int k = 0; k < 3; k++) vecs.push_back(mk(1, 0, 1, 0, 0, 4, 1, 1, 0, 0, 0, 0, 'h1234));
    for (int k = 0; k < 3; k++) vecs.push_back(mk(1, 0, 1, 0, 0, 5, 1, 1, 0, 0, 0, 0, 'h1234));
    vecs.push_back(mk(1, 0, 1, 0, 0,       6, 1, 1, 1, 0, 0, 0, 'h1234));
    vecs.push_back(mk(1, 0, 1, 0, 0,       0, 1, 0, 1, 0, 1, 0, 'h1234));
    vecs.push_back(mk(1, 0, 1, 0, 0,       0, 1, 0, 1, 0, 0, 0, 'h1234));

    foreach (vecs[n]) begin
      apply(vecs[n].r, vecs[n].d, vecs[n].u, vecs[n].b, vecs[n].res);
      exp_outs($sformatf("vec%0d", n), vecs[n].st, vecs[n].p, vecs[n].i, vecs[n].a,
               vecs[n].dd, vecs[n].ud, vecs[n].de, vecs[n].clh);
    end

    // Busy for five DRAIN cycles, then capture on the DRAIN->ISO edge.
    apply(1, 1, 0, 1, 0);
    exp_outs("bz_enter", 1, 1, 0, 1, 0, 0, 0, 'h1234);
    for (int k = 0; k < 5; k++) begin
      apply(1, 1, 0, 1, 'h1111);
      exp_outs($sformatf("bz_wait%0d", k), 1, 1, 0, 1, 0, 0, 0, 'h1234);
    end
    apply(1, 1, 0, 0, 'hBEEF);
    exp_outs("bz_iso", 2, 1, 1, 1, 0, 0, 0, 'hBEEF);
    apply(1, 1, 0, 0, 'h0);
    exp_outs("bz_iso2", 2, 1, 1, 1, 0, 0, 0, 'hBEEF);
    apply(1, 1, 0, 0, 'h0);
    exp_outs("bz_off", 3, 0, 1, 0, 1, 0, 0, 'hBEEF);
    apply(1, 0, 0, 0, 'h7777);
    exp_outs("bz_hold", 3, 0, 1, 0, 0, 0, 0, 'hBEEF);

    // Power-up latency: RAMP for 4, RST for 3, UNISO for 1, then ON.
    for (int k = 0; k < 8; k++) begin
      int st;
      st = (k < 4) ? 4 : (k < 7) ? 5 : 6;
      apply(1, 0, 1, 0, 0);
      exp_outs($sformatf("up%0d", k), st, 1, 1, (st == 6) ? 1 : 0, 0, 0, 0, 'hBEEF);
    end
    apply(1, 0, 1, 0, 0);
    exp_outs("up_on", 0, 1, 0, 1, 0, 1, 0, 'hBEEF);

    // Drain timeout with the request held, then re-entry into DRAIN.
    apply(1, 1, 0, 1, 0);
    exp_outs("to_enter", 1, 1, 0, 1, 0, 0, 0, 'hBEEF);
    for (int k = 0; k < DRAIN_MAX - 1; k++) begin
      apply(1, 1, 0, 1, 0);
      exp_outs($sformatf("to_wait%0d", k), 1, 1, 0, 1, 0, 0, 0, 'hBEEF);
    end
    apply(1, 1, 0, 1, 0);
    exp_outs("to_abort", 0, 1, 0, 1, 0, 0, 1, 'hBEEF);
    apply(1, 1, 0, 1, 0);
    exp_outs("to_reenter", 1, 1, 0, 1, 0, 0, 0, 'hBEEF);

    // Finish the power-down, start a power-up, reset in the middle of RAMP.
    apply(1, 0, 0, 0, 'hCAFE);
    exp_outs("mr_iso", 2, 1, 1, 1, 0, 0, 0, 'hCAFE);
    apply(1, 0, 0, 0, 0);
    apply(1, 0, 0, 0, 0);
    exp_outs("mr_off", 3, 0, 1, 0, 1, 0, 0, 'hCAFE);
    for (int k = 0; k < 3; k++) begin
      apply(1, 0, 1, 0, 0);
      exp_outs($sformatf("mr_ramp%0d", k), 4, 1, 1, 0, 0, 0, 0, 'hCAFE);
    end
    apply(0, 0, 1, 0, 0);
    exp_outs("mr_rst", 5, 1, 1, 0, 0, 0, 0, int'(CLAMP_VAL));
    for (int k = 0; k < RST_HOLD - 1; k++) begin
      apply(1, 0, 0, 0, 0);
      exp_outs($sformatf("mr_hold%0d", k), 5, 1, 1, 0, 0, 0, 0, int'(CLAMP_VAL));
    end
    apply(1, 0, 0, 0, 0);
    exp_outs("mr_uniso", 6, 1, 1, 1, 0, 0, 0, int'(CLAMP_VAL));
    apply(1, 0, 0, 0, 0);
    exp_outs("mr_on", 0, 1, 0, 1, 0, 1, 0, int'(CLAMP_VAL));

    // Random levels: requests and busy change rarely so long holds occur.
    begin
      int d, u, b;
      d = 0; u = 0; b = 0;
      for (int n = 0; n < 3000; n++) begin
        if ($urandom_range(11) == 0) d = 1 - d;
        if ($urandom_range(11) == 0) u = 1 - u;
        if ($urandom_range(7) == 0) b = 1 - b;
        apply(($urandom_range(149) == 0) ? 0 : 1, d, u, b, int'($urandom_range(65535)));
        exp_model($sformatf("rnd%0d", n));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
